// File: rtl/led_stream_sender_pkg.sv
// led_stream_sender_pkg: shared LED-strip globals (strip length, WS2812 timing defaults,
// buffer address map) and the sender FSM encoding.
package led_stream_sender_pkg;

    localparam int LEDS_NUM   = 2;
    localparam int T0H_DEF    = 20;
    localparam int T1H_DEF    = 40;
    localparam int TBIT_DEF   = 62;
    localparam int TLATCH_DEF = 2500;

    localparam logic [31:0] BUF_BASE   = 32'h0000_1000;
    localparam logic [31:0] BUF_STRIDE = 32'h0000_0100;

    typedef enum logic [2:0] {IDLE, INIT, FETCH, LOAD, SHIFT, LATCH, DONE} state_e;

    function automatic logic [31:0] addr_for_buf_id(input logic [31:0] id);
        return BUF_BASE + id * BUF_STRIDE;
    endfunction

    function automatic int cnt_width(input int tbit, input int tlatch);
        return $clog2((tbit > tlatch ? tbit : tlatch) + 1);
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: one WS2812 bit period per start pulse; dout high for T0H/T1H clocks,
// done flags the last of the TBIT clocks so the next start can follow without a gap.
module ws2812_bit_encoder #(
    parameter int T0H  = 20,
    parameter int T1H  = 40,
    parameter int TBIT = 62,
    parameter int CW   = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic bit_in,
    output logic dout,
    output logic done
);

    localparam logic [CW-1:0] LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] HI0  = CW'(T0H);
    localparam logic [CW-1:0] HI1  = CW'(T1H);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          bit_q, bit_d;
    logic          dout_q, dout_d;

    assign done = busy_q && cnt_q == LAST;
    assign dout = dout_q;

    always_comb begin
        busy_d = start || (busy_q && !done);
        cnt_d  = (start || !busy_q || done) ? '0 : cnt_q + CW'(1);
        bit_d  = start ? bit_in : bit_q;
        dout_d = busy_d && cnt_d < (bit_d ? HI1 : HI0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            bit_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            bit_q  <= bit_d;
            dout_q <= dout_d;
        end
    end

endmodule

// File: rtl/led_stream_sender.sv
// led_stream_sender: reads one GRB word per LED over Wishbone and streams it MSB-first as
// WS2812 bits, prefetching the next word while the current one shifts out.
module led_stream_sender
    import led_stream_sender_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int T0H        = T0H_DEF,
    parameter int T1H        = T1H_DEF,
    parameter int TBIT       = TBIT_DEF,
    parameter int TLATCH     = TLATCH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] wbm_address,
    input  logic [DATA_WIDTH-1:0] wbm_readdata,
    output logic                  wbm_strobe,
    output logic                  wbm_cycle,
    output logic                  wbm_write,
    input  logic                  wbm_ack,
    input  logic [DATA_WIDTH-1:0] buf_id,
    input  logic                  send_buf,
    output logic                  buf_sent,
    output logic                  led_dout
);

    localparam int                    CW         = cnt_width(TBIT, TLATCH);
    localparam logic [9:0]            LAST_LED   = 10'(LEDS_NUM);
    localparam logic [CW-1:0]         LATCH_LAST = CW'(TLATCH - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [9:0]            led_count_q, led_count_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]         lat_cnt_q, lat_cnt_d;
    logic [23:0]           pf_q, pf_d;
    logic [23:0]           shift_q, shift_d;
    logic                  pf_valid_q, pf_valid_d;
    logic                  strobe_q, strobe_d;
    logic                  sent_q, sent_d;
    logic                  enc_start, enc_bit, enc_done, pf_ack;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  unused_rdata;

    assign base_addr    = ADDR_WIDTH'(addr_for_buf_id(32'(buf_id)));
    assign unused_rdata = ^wbm_readdata[DATA_WIDTH-1:24];
    assign pf_ack       = strobe_q && wbm_ack;

    assign wbm_address = addr_q;
    assign wbm_strobe  = strobe_q;
    assign wbm_cycle   = strobe_q;
    assign wbm_write   = 1'b0;
    assign buf_sent    = sent_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        led_count_d = led_count_q;
        bit_cnt_d   = bit_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        pf_d        = pf_q;
        pf_valid_d  = pf_valid_q;
        shift_d     = shift_q;
        strobe_d    = strobe_q;
        enc_start   = 1'b0;
        enc_bit     = shift_q[22];
        case (state_q)
            IDLE: state_d = send_buf ? INIT : IDLE;
            INIT: begin
                addr_d      = base_addr;
                led_count_d = 10'd1;
                strobe_d    = 1'b1;
                state_d     = FETCH;
            end
            FETCH: if (pf_ack) begin
                strobe_d = 1'b0;
                pf_d     = wbm_readdata[23:0];
                state_d  = LOAD;
            end
            LOAD: begin
                shift_d    = pf_q;
                bit_cnt_d  = '0;
                addr_d     = addr_q + STEP;
                pf_valid_d = 1'b0;
                strobe_d   = led_count_q < LAST_LED;
                enc_start  = 1'b1;
                enc_bit    = pf_q[23];
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (pf_ack) begin
                    strobe_d   = 1'b0;
                    pf_d       = wbm_readdata[23:0];
                    pf_valid_d = 1'b1;
                end
                // an ack landing on the last clock of bit 23 still counts as a completed prefetch
                if (enc_done && bit_cnt_q != 5'd23) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    enc_start = 1'b1;
                end else if (enc_done && led_count_q == LAST_LED) begin
                    lat_cnt_d = '0;
                    state_d   = LATCH;
                end else if (enc_done) begin
                    led_count_d = led_count_q + 10'd1;
                    state_d     = (pf_valid_q || pf_ack) ? LOAD : FETCH;
                end
            end
            LATCH: begin
                lat_cnt_d = lat_cnt_q + CW'(1);
                state_d   = (lat_cnt_q == LATCH_LAST) ? DONE : LATCH;
            end
            DONE: state_d = send_buf ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        sent_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            led_count_q <= '0;
            bit_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            pf_q        <= '0;
            pf_valid_q  <= 1'b0;
            shift_q     <= '0;
            strobe_q    <= 1'b0;
            sent_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            led_count_q <= led_count_d;
            bit_cnt_q   <= bit_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            pf_q        <= pf_d;
            pf_valid_q  <= pf_valid_d;
            shift_q     <= shift_d;
            strobe_q    <= strobe_d;
            sent_q      <= sent_d;
        end
    end

    ws2812_bit_encoder #(
        .T0H (T0H),
        .T1H (T1H),
        .TBIT(TBIT),
        .CW  (CW)
    ) u_enc (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (enc_start),
        .bit_in (enc_bit),
        .dout   (led_dout),
        .done   (enc_done)
    );

endmodule
